cntr_seq_machine: RTL and testbench
===================================

CNTR_SEQ_MACHINE -- requirements
Module: cntr_seq_machine

Interface
REQ-001 The block SHALL have parameter SHIFTER_MODE_WIDTH, default 2, giving the shifter_mode field width (0 SHALL be legal: shifter_mode driven 0, field absent from entries).
REQ-002 The block SHALL have parameter B_D, default 4, giving the B buffer depth; AW = max(1, clog2(B_D)).
REQ-003 The block SHALL have parameter SEQ_D, default 4 (≥1), giving the sequence table depth; SW = max(1, clog2(SEQ_D)).
REQ-004 The block SHALL have parameter OUTER_W, default 4, giving the outer-loop counter width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, synchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit, a pulse that launches a run from IDLE.
REQ-008 The block SHALL have port hp_en, input, 1 bit, step enable; RUN advances only when it is 1.
REQ-009 The block SHALL have outputs a_s, b_s and acc_mode, each 1 bit, driven from the current sequence entry.
REQ-010 The block SHALL have output b_addr, AW bits, the B buffer read address.
REQ-011 The block SHALL have output shifter_mode, max(1,SHIFTER_MODE_WIDTH) bits, driven from the current entry.
REQ-012 The block SHALL have output busy, 1 bit, equal to 1 iff the state is RUN.
REQ-013 The block SHALL have ports config_en (input, 1 bit), config_in (input, 1 bit) and config_out (output, 1 bit) forming the serial configuration chain.

Function
REQ-014 The entry layout SHALL be {a_s, b_s, b_addr_inc[AW], shifter_mode, acc_mode} (MSB to LSB), W = 3+AW+SHIFTER_MODE_WIDTH bits.
REQ-015 The chain order from config_in SHALL be: seq_limit[SW], seq_mem[SEQ_D*W], base_limit[AW], base_step[AW], outer_limit[OUTER_W] (macro only); each field SHALL shift LSB-first-in, and config_out SHALL be the MSB of the last field.
REQ-016 While config_en=1, the chain SHALL shift one bit per clock, and the step, base and outer counters and the state SHALL hold.
REQ-017 The state machine SHALL have two states, IDLE and RUN; start=1 with config_en=0 in IDLE SHALL enter RUN next cycle with step=0, base=0, outer=0, and start in RUN SHALL be ignored.
REQ-018 In RUN with hp_en=1 and step≠eff_limit, step SHALL increment; eff_limit SHALL be min(seq_limit, SEQ_D-1).
REQ-019 In RUN with hp_en=1 and step=eff_limit, step SHALL go to 0, and base SHALL go to 0 if base=base_limit, else to (base+base_step) mod 2^AW.
REQ-020 In RUN with hp_en=0, all counters SHALL hold.
REQ-021 In RUN, the outputs SHALL be combinational from entry[step], with b_addr = (base+b_addr_inc) mod 2^AW.
REQ-022 In IDLE, a_s, b_s, acc_mode, shifter_mode and b_addr SHALL all be 0.

Reset
REQ-023 When reset=0 at a rising edge, the block SHALL enter IDLE with step=0, base=0, outer=0 and done=0, taking priority over start, hp_en and a mid-run state.
REQ-024 Configuration registers SHALL NOT be reset, and chain shifting under config_en SHALL proceed regardless of reset.

Configuration
REQ-025 With macro STATE_MACHINE_OUTER_LOOP_EN defined, the outer_limit field and output done (1 bit) SHALL exist; at each sequence wrap (REQ-019), outer SHALL increment, except when outer=outer_limit, in which case the state SHALL return to IDLE and done SHALL be 1 for exactly the following cycle.
REQ-026 Without STATE_MACHINE_OUTER_LOOP_EN, there SHALL be no outer counter, no outer_limit field and no done port; RUN SHALL continue until reset.

Verification (defaults: AW=2, SW=2, W=7; chain length 38 with macro, 34 without)
REQ-027 Program seq_limit=1, e0.inc=0, e1.inc=1, base_step=2, base_limit=2, outer_limit=2; then start and hold hp_en=1 -> b_addr SHALL be 0,1,2,3,0,1, then IDLE, with a one-cycle done pulse and busy falling.
REQ-028 Same program with hp_en toggling 1,0,1,0 -> b_addr SHALL hold during hp_en=0 cycles, giving the same 6-value sequence over 12 cycles.
REQ-029 seq_limit=3 with entries a_s=1,0,1,0 and acc_mode=0,0,0,1 -> a_s/acc_mode SHALL follow the table per step and wrap to entry 0.
REQ-030 Drive reset=0 at step 2 of a run -> next cycle SHALL be IDLE with all outputs 0; start afterwards SHALL replay from b_addr=0 with config intact.
REQ-031 Shift 38 known bits in, then 38 more -> config_out SHALL reproduce the first pattern bit-for-bit, and counters SHALL stay frozen throughout.
REQ-032 Apply start together with config_en=1 -> start SHALL be ignored and busy SHALL stay 0.

Source files
------------

// File: rtl/cntr_seq_machine.sv
// Sequence-table driven counter: serially configured entry table stepped by hp_en, no output latency (outputs combinational from state).
// hp_en=0 stalls all counters; config_en freezes the machine while the chain shifts. Optional outer loop and done under STATE_MACHINE_OUTER_LOOP_EN.
module cntr_seq_machine #(
  parameter int SHIFTER_MODE_WIDTH = 2,
  parameter int B_D                = 4,
  parameter int SEQ_D              = 4,
  parameter int OUTER_W            = 4,
  localparam int AW  = (B_D > 2) ? $clog2(B_D) : 1,
  localparam int SW  = (SEQ_D > 2) ? $clog2(SEQ_D) : 1,
  localparam int SMW = (SHIFTER_MODE_WIDTH > 0) ? SHIFTER_MODE_WIDTH : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           hp_en,
  output logic           a_s,
  output logic           b_s,
  output logic           acc_mode,
  output logic [AW-1:0]  b_addr,
  output logic [SMW-1:0] shifter_mode,
  output logic           busy,
`ifdef STATE_MACHINE_OUTER_LOOP_EN
  output logic           done,
`endif
  input  logic           config_en,
  input  logic           config_in,
  output logic           config_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int W      = 3 + AW + SHIFTER_MODE_WIDTH;
  localparam int MEM_W  = SEQ_D * W;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
  localparam int OL_W   = OUTER_W;
`else
  localparam int OL_W   = 0 * OUTER_W;
`endif
  localparam int MEM_LSB = SW;
  localparam int BL_LSB  = SW + MEM_W;
  localparam int BS_LSB  = BL_LSB + AW;
  localparam int CHAIN_W = SW + MEM_W + 2 * AW + OL_W;

  localparam logic [SW-1:0] MAX_STEP = SW'(SEQ_D - 1);

  // Configuration chain: config_in enters bit 0 (seq_limit LSB), config_out is the top bit.
  logic [CHAIN_W-1:0] chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (config_en) chain_d = {chain_q[CHAIN_W-2:0], config_in};
  end

  always_ff @(posedge clk) begin
    chain_q <= chain_d;
  end

  assign config_out = chain_q[CHAIN_W-1];

  logic [SW-1:0]    seq_limit;
  logic [MEM_W-1:0] seq_mem;
  logic [AW-1:0]    base_limit;
  logic [AW-1:0]    base_step;
  logic [SW-1:0]    eff_limit;

  assign seq_limit  = chain_q[0 +: SW];
  assign seq_mem    = chain_q[MEM_LSB +: MEM_W];
  assign base_limit = chain_q[BL_LSB +: AW];
  assign base_step  = chain_q[BS_LSB +: AW];
  assign eff_limit  = (seq_limit > MAX_STEP) ? MAX_STEP : seq_limit;

`ifdef STATE_MACHINE_OUTER_LOOP_EN
  logic [OUTER_W-1:0] outer_limit;
  assign outer_limit = chain_q[BS_LSB + AW +: OUTER_W];
`endif

  logic [0:0]  state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [AW-1:0] base_q, base_d;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
  logic [OUTER_W-1:0] outer_q, outer_d;
  logic               done_q, done_d;
`endif

  // Current entry; a step beyond the table (possible only after a mid-run reconfigure) reads as zero.
  logic [W-1:0] entry;

  always_comb begin
    entry = '0;
    for (int i = 0; i < SEQ_D; i++) begin
      if (step_q == SW'(i)) entry = seq_mem[i*W +: W];
    end
  end

  logic           ent_a_s;
  logic           ent_b_s;
  logic           ent_acc;
  logic [AW-1:0]  ent_inc;
  logic [SMW-1:0] ent_sm;

  assign ent_acc = entry[0];
  assign ent_inc = entry[SHIFTER_MODE_WIDTH+1 +: AW];
  assign ent_b_s = entry[W-2];
  assign ent_a_s = entry[W-1];

  generate
    if (SHIFTER_MODE_WIDTH > 0) begin : g_sm
      assign ent_sm = entry[1 +: SHIFTER_MODE_WIDTH];
    end else begin : g_no_sm
      assign ent_sm = '0;
    end
  endgenerate

  always_comb begin
    a_s          = 1'b0;
    b_s          = 1'b0;
    acc_mode     = 1'b0;
    shifter_mode = '0;
    b_addr       = '0;
    if (state_q == RUN) begin
      a_s          = ent_a_s;
      b_s          = ent_b_s;
      acc_mode     = ent_acc;
      shifter_mode = ent_sm;
      b_addr       = base_q + ent_inc;
    end
  end

  assign busy = (state_q == RUN);
`ifdef STATE_MACHINE_OUTER_LOOP_EN
  assign done = done_q;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    base_d  = base_q;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
    outer_d = outer_q;
    done_d  = 1'b0;
`endif
    if (!config_en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            step_d  = '0;
            base_d  = '0;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
            outer_d = '0;
`endif
          end
        end
        RUN: begin
          if (hp_en) begin
            if (step_q != eff_limit) begin
              step_d = step_q + 1'b1;
            end else begin
              step_d = '0;
              base_d = (base_q == base_limit) ? '0 : base_q + base_step;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
              if (outer_q == outer_limit) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                outer_d = outer_q + 1'b1;
              end
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      base_q  <= '0;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
      outer_q <= '0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      base_q  <= base_d;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
      outer_q <= outer_d;
      done_q  <= done_d;
`endif
    end
  end

endmodule

// File: tb/tb_cntr_seq_machine.sv
// Directed bench for cntr_seq_machine at default parameters; builds with or without STATE_MACHINE_OUTER_LOOP_EN.
module tb_cntr_seq_machine;

`ifdef STATE_MACHINE_OUTER_LOOP_EN
  localparam int L = 38;
`else
  localparam int L = 34;
`endif

  logic       clk;
  logic       reset;
  logic       start;
  logic       hp_en;
  logic       a_s;
  logic       b_s;
  logic       acc_mode;
  logic [1:0] b_addr;
  logic [1:0] shifter_mode;
  logic       busy;
  logic       done;
  logic       config_en;
  logic       config_in;
  logic       config_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [L-1:0] p1;
  logic [L-1:0] p2;
  logic [L-1:0] pat_a;
  logic [63:0]  seed;
  int           exp6[6] = '{0, 1, 2, 3, 0, 1};

  cntr_seq_machine dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .hp_en        (hp_en),
    .a_s          (a_s),
    .b_s          (b_s),
    .acc_mode     (acc_mode),
    .b_addr       (b_addr),
    .shifter_mode (shifter_mode),
    .busy         (busy),
`ifdef STATE_MACHINE_OUTER_LOOP_EN
    .done         (done),
`endif
    .config_en    (config_en),
    .config_in    (config_in),
    .config_out   (config_out)
  );

`ifndef STATE_MACHINE_OUTER_LOOP_EN
  assign done = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ent(input logic a, input logic b, input logic [1:0] inc,
                                     input logic [1:0] sm, input logic acc);
    return {a, b, inc, sm, acc};
  endfunction

  function automatic logic [L-1:0] make_cfg(input logic [1:0] sl, input logic [27:0] mem,
                                            input logic [1:0] bl, input logic [1:0] bs,
                                            input logic [3:0] ol);
`ifdef STATE_MACHINE_OUTER_LOOP_EN
    return {ol, bs, bl, mem, sl};
`else
    return {bs, bl, mem, sl} | L'(ol & 4'h0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [L-1:0] v);
    config_en = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      config_in = v[i];
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_run();
    start = 1'b0;
    hp_en = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (b_addr !== 2'd0) begin n_bad++; $display("FAIL reset_b_addr got %0d want 0", b_addr); end
    n_cmp++; if ({a_s, b_s, acc_mode, shifter_mode} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs got %b want 00000", {a_s, b_s, acc_mode, shifter_mode});
    end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_seq_hold();
    hp_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (b_addr !== 2'(exp6[k])) begin n_bad++; $display("FAIL hold_b_addr[%0d] got %0d want %0d", k, b_addr, exp6[k]); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_busy[%0d] got %b want 1", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hold_done[%0d] got %b want 0", k, done); end
      start = (k == 2);
      tick();
    end
    start = 1'b0;
`ifdef STATE_MACHINE_OUTER_LOOP_EN
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_end_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL hold_end_done got %b want 1", done); end
    n_cmp++; if (b_addr !== 2'd0) begin n_bad++; $display("FAIL hold_end_b_addr got %0d want 0", b_addr); end
    hp_en = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hold_done_pulse got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle_busy got %b want 0", busy); end
`else
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hold_cont_busy got %b want 1", busy); end
    n_cmp++; if (b_addr !== 2'd2) begin n_bad++; $display("FAIL hold_cont_b_addr got %0d want 2", b_addr); end
`endif
    stop_run();
  endtask

  task automatic test_hp_toggle();
    hp_en = 1'b0;
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      hp_en = (k % 2 == 1);
      n_cmp++; if (b_addr !== 2'(exp6[k/2])) begin n_bad++; $display("FAIL toggle_b_addr[%0d] got %0d want %0d", k, b_addr, exp6[k/2]); end
      tick();
    end
`ifdef STATE_MACHINE_OUTER_LOOP_EN
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL toggle_end_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL toggle_end_done got %b want 1", done); end
`else
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL toggle_end_busy got %b want 1", busy); end
`endif
    stop_run();
  endtask

  task automatic test_table();
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] ec;
    int         i;
    ea = 4'b0101;
    eb = 4'b0110;
    ec = 4'b1000;
    load_cfg(p2);
    hp_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      i = k % 4;
      n_cmp++; if (a_s !== ea[i]) begin n_bad++; $display("FAIL table_a_s[%0d] got %b want %b", k, a_s, ea[i]); end
      n_cmp++; if (b_s !== eb[i]) begin n_bad++; $display("FAIL table_b_s[%0d] got %b want %b", k, b_s, eb[i]); end
      n_cmp++; if (acc_mode !== ec[i]) begin n_bad++; $display("FAIL table_acc[%0d] got %b want %b", k, acc_mode, ec[i]); end
      n_cmp++; if (shifter_mode !== 2'(i)) begin n_bad++; $display("FAIL table_sm[%0d] got %0d want %0d", k, shifter_mode, i); end
      n_cmp++; if (b_addr !== 2'd0) begin n_bad++; $display("FAIL table_b_addr[%0d] got %0d want 0", k, b_addr); end
      tick();
    end
    stop_run();
  endtask

  task automatic test_reset_mid();
    hp_en = 1'b1;
    pulse_start();
    tick();
    tick();
    n_cmp++; if (b_addr !== 2'd2) begin n_bad++; $display("FAIL mid_pre_b_addr got %0d want 2", b_addr); end
    reset = 1'b0;
    start = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if ({a_s, b_s, acc_mode, shifter_mode, b_addr} !== 7'b0) begin
      n_bad++; $display("FAIL mid_outs got %b want 0000000", {a_s, b_s, acc_mode, shifter_mode, b_addr});
    end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", done); end
    start = 1'b0;
    reset = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle_busy got %b want 0", busy); end
    pulse_start();
    n_cmp++; if (b_addr !== 2'd0) begin n_bad++; $display("FAIL mid_replay0 got %0d want 0", b_addr); end
    n_cmp++; if (a_s !== 1'b1) begin n_bad++; $display("FAIL mid_replay_a_s got %b want 1", a_s); end
    n_cmp++; if (shifter_mode !== 2'd3) begin n_bad++; $display("FAIL mid_replay_sm got %0d want 3", shifter_mode); end
    tick();
    n_cmp++; if (b_addr !== 2'd1) begin n_bad++; $display("FAIL mid_replay1 got %0d want 1", b_addr); end
    stop_run();
  endtask

  task automatic test_chain();
    hp_en = 1'b1;
    pulse_start();
    tick();
    tick();
    n_cmp++; if (b_addr !== 2'd2) begin n_bad++; $display("FAIL chain_pre_b_addr got %0d want 2", b_addr); end
    config_en = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      config_in = pat_a[i];
      tick();
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL chain_mid_busy got %b want 1", busy); end
    for (int i = L - 1; i >= 0; i--) begin
      config_in = p1[i];
      n_cmp++; if (config_out !== pat_a[i]) begin n_bad++; $display("FAIL chain_out[%0d] got %b want %b", i, config_out, pat_a[i]); end
      tick();
    end
    config_en = 1'b0;
    config_in = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL chain_busy got %b want 1", busy); end
    n_cmp++; if (b_addr !== 2'd2) begin n_bad++; $display("FAIL chain_frozen_b_addr got %0d want 2", b_addr); end
    n_cmp++; if (a_s !== 1'b1) begin n_bad++; $display("FAIL chain_frozen_a_s got %b want 1", a_s); end
    tick();
    n_cmp++; if (b_addr !== 2'd3) begin n_bad++; $display("FAIL chain_resume_b_addr got %0d want 3", b_addr); end
    stop_run();
  endtask

  task automatic test_start_cfg();
    config_en = 1'b1;
    config_in = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL startcfg_busy[%0d] got %b want 0", k, busy); end
    end
    config_en = 1'b0;
    start = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL startcfg_after got %b want 0", busy); end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    hp_en     = 1'b0;
    config_en = 1'b0;
    config_in = 1'b0;
    seed  = 64'h9C3A_5E71_D2B4_6F08;
    pat_a = seed[L-1:0];
    p1 = make_cfg(2'd1, {ent(0, 0, 2'd0, 2'd0, 0), ent(0, 0, 2'd0, 2'd0, 0),
                         ent(0, 1, 2'd1, 2'd1, 1), ent(1, 1, 2'd0, 2'd3, 1)},
                  2'd2, 2'd2, 4'd2);
    p2 = make_cfg(2'd3, {ent(0, 0, 2'd0, 2'd3, 1), ent(1, 1, 2'd0, 2'd2, 0),
                         ent(0, 1, 2'd0, 2'd1, 0), ent(1, 0, 2'd0, 2'd0, 0)},
                  2'd0, 2'd0, 4'd15);
    tick();
    tick();
    test_reset();
    load_cfg(p1);
    reset = 1'b1;
    tick();
    test_seq_hold();
    test_hp_toggle();
    test_reset_mid();
    test_chain();
    test_table();
    test_start_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
